// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// default clock/line rates and a helper for the bit period.
package uart_rx_byte_pkg;

    // Receiver FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    // Board defaults: Nexys2 50 MHz oscillator, 115200 baud line.
    localparam int DEFAULT_CLK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUD     = 115_200;

    // Clock cycles per serial bit, truncated.
    function automatic int bit_ticks(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte_sync2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs. The reset value
// is a parameter so idle-high lines (UART rx) and idle-low lines (buttons,
// switches) both come out of reset in their idle state.
module sync2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver. The rx pin is synchronized, the start bit is confirmed
// at its midpoint, then each data bit and the stop bit are sampled one bit
// period apart.
//
// Output handshake: rx_done is a valid-only strobe with no ready. It is high
// for exactly one cycle when rx_data takes a new byte; the consumer must take
// rx_data before the next rx_done. frame_err is a one-cycle strobe for a low
// stop bit and never coincides with rx_done.
//
// dbg_state mirrors the FSM state register for observation.
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int BAUD     = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int BIT_TICKS = bit_ticks(CLK_FREQ, BAUD);
    localparam int HALF      = BIT_TICKS / 2;
    localparam int CW        = $clog2(BIT_TICKS);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    // Too few ticks per bit leaves no room for a mid-bit sample point.
    generate
        if (BIT_TICKS < 4) begin : g_bad_rate
            $error("uart_rx_byte: CLK_FREQ/BAUD must be at least 4");
        end
    endgenerate

    logic       rx_s;
    state_t     state;
    state_t     state_next;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       expired;
    logic       done_next;
    logic       err_next;

    // Line idles high, so the synchronizer resets to 1.
    sync2ff #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx),
        .q    (rx_s)
    );

    // Tick counter reaches the last tick of the current state's period.
    always_comb begin
        expired = 1'b0;
        case (state)
            START:       expired = (cnt == HALF_LAST);
            DATA, STOP:  expired = (cnt == BIT_LAST);
            default:     expired = 1'b0;
        endcase
    end

    // State register; busy is registered alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!rx_s) state_next = START;
            START:     if (expired) state_next = rx_s ? IDLE : DATA;
            DATA:      if (expired && (bit_idx == 3'd7)) state_next = STOP;
            STOP:      if (expired) state_next = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Stop-bit outcome decoded one cycle ahead of the registered strobes.
    always_comb begin
        done_next = 1'b0;
        err_next  = 1'b0;
        if ((state == STOP) && expired) begin
            done_next = rx_s;
            err_next  = !rx_s;
        end
    end

    // Tick counter, bit index and shift register. The counter restarts on
    // every state entry and every period expiry, and rests at zero while
    // waiting on the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            if ((state_next != state) || expired ||
                (state == IDLE) || (state == WAIT_HIGH)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (state == START) begin
                bit_idx <= 3'd0;
            end else if ((state == DATA) && expired) begin
                // LSB arrives first, so shift right and load at bit 7.
                shreg   <= {rx_s, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // Registered outputs; rx_data only moves on a good stop bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data   <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= done_next;
            frame_err <= err_next;
            if (done_next) begin
                rx_data <= shreg;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Testbench for uart_rx_byte at CLK_FREQ=1000, BAUD=100 (10 ticks per bit).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_rx_byte;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int BIT      = CLK_FREQ / BAUD;
    localparam int HALF     = BIT / 2;
    localparam int SYNC     = 2;
    // Cycles from driving the start bit to seeing the strobe: one edge to
    // reach the pin flop, synchronizer delay, half a bit to the start
    // midpoint, eight data bits plus the stop bit.
    localparam int LAT      = 1 + SYNC + HALF + 9 * BIT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       busy;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Monitor records
    int         obs_done_cyc_q[$];
    logic [7:0] obs_data_q[$];
    logic       obs_busy_q[$];
    int         obs_err_cyc_q[$];
    int         both_cnt = 0;

    // Reference model expectations
    int         exp_done_cyc_q[$];
    logic [7:0] exp_q[$];
    int         exp_err_cyc_q[$];
    logic [7:0] model_rx_data = 8'h00;

    uart_rx_byte #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .frame_err(frame_err),
        .busy     (busy),
        .dbg_state(dbg_state)
    );

    // Clock and cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor
    always @(negedge clk) begin
        if (rx_done) begin
            obs_done_cyc_q.push_back(cyc);
            obs_data_q.push_back(rx_data);
            obs_busy_q.push_back(busy);
        end
        if (frame_err) obs_err_cyc_q.push_back(cyc);
        if (rx_done && frame_err) both_cnt = both_cnt + 1;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic clear_all();
        obs_done_cyc_q.delete();
        obs_data_q.delete();
        obs_busy_q.delete();
        obs_err_cyc_q.delete();
        exp_done_cyc_q.delete();
        exp_q.delete();
        exp_err_cyc_q.delete();
    endtask

    // Model: a frame whose start bit is driven at cycle s produces one strobe
    // LAT cycles later, rx_done with the byte if the stop bit is high,
    // frame_err otherwise.
    task automatic model_frame(input int s, input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            exp_done_cyc_q.push_back(s + LAT);
            exp_q.push_back(b);
            model_rx_data = b;
        end else begin
            exp_err_cyc_q.push_back(s + LAT);
        end
    endtask

    // Driver: start bit, 8 data bits LSB first, stop bit. Call on a falling edge.
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit, output int s);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        s = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int busy_hits;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        n_checks++; if (rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_rx_done got=%b exp=0", rx_done); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        model_rx_data = 8'h00;
        busy_hits = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_hits++;
        end
        n_checks++; if (busy_hits != 0) begin n_fail++; $display("FAIL idle_busy got=%0d busy cycles exp=0", busy_hits); end
    endtask

    task automatic test_a5();
        int s;
        clear_all();
        drive_frame(8'hA5, 1'b1, s);
        model_frame(s, 8'hA5, 1'b1);
        repeat (5) @(negedge clk);
        n_checks++; if (obs_done_cyc_q.size() != 1) begin n_fail++; $display("FAIL a5_done_count got=%0d exp=1", obs_done_cyc_q.size()); end
        if (obs_done_cyc_q.size() >= 1) begin
            n_checks++; if (obs_done_cyc_q[0] != exp_done_cyc_q[0]) begin n_fail++; $display("FAIL a5_done_cycle got=%0d exp=%0d", obs_done_cyc_q[0], exp_done_cyc_q[0]); end
            n_checks++; if (obs_data_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL a5_data got=%h exp=%h", obs_data_q[0], exp_q[0]); end
            n_checks++; if (obs_busy_q[0] !== 1'b0) begin n_fail++; $display("FAIL a5_busy_at_done got=%b exp=0", obs_busy_q[0]); end
        end
        n_checks++; if (obs_err_cyc_q.size() != 0) begin n_fail++; $display("FAIL a5_frame_err got=%0d pulses exp=0", obs_err_cyc_q.size()); end
        n_checks++; if (rx_data !== model_rx_data) begin n_fail++; $display("FAIL a5_rx_data got=%h exp=%h", rx_data, model_rx_data); end
    endtask

    task automatic test_glitch();
        int s;
        clear_all();
        s  = cyc;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        // cyc == s+3: start edge seen
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_rise got=%b exp=1 cyc=%0d", busy, cyc - s); end
        repeat (SYNC + HALF - 3) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_hold got=%b exp=1 cyc=%0d", busy, cyc - s); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_fall got=%b exp=0 cyc=%0d", busy, cyc - s); end
        repeat (110) @(negedge clk);
        n_checks++; if (obs_done_cyc_q.size() + obs_err_cyc_q.size() != 0) begin n_fail++; $display("FAIL glitch_pulses got=%0d exp=0", obs_done_cyc_q.size() + obs_err_cyc_q.size()); end
        n_checks++; if (rx_data !== model_rx_data) begin n_fail++; $display("FAIL glitch_rx_data got=%h exp=%h", rx_data, model_rx_data); end
    endtask

    task automatic test_frame_err();
        int s;
        int s2;
        clear_all();
        drive_frame(8'h3C, 1'b0, s);
        model_frame(s, 8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        n_checks++; if (obs_err_cyc_q.size() != 1) begin n_fail++; $display("FAIL ferr_count got=%0d exp=1", obs_err_cyc_q.size()); end
        if (obs_err_cyc_q.size() >= 1) begin
            n_checks++; if (obs_err_cyc_q[0] != exp_err_cyc_q[0]) begin n_fail++; $display("FAIL ferr_cycle got=%0d exp=%0d", obs_err_cyc_q[0], exp_err_cyc_q[0]); end
        end
        n_checks++; if (obs_done_cyc_q.size() != 0) begin n_fail++; $display("FAIL ferr_done got=%0d exp=0", obs_done_cyc_q.size()); end
        n_checks++; if (rx_data !== model_rx_data) begin n_fail++; $display("FAIL ferr_rx_data got=%h exp=%h", rx_data, model_rx_data); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_low_line got=%b exp=1", busy); end
        rx = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_release got=%b exp=0", busy); end
        clear_all();
        drive_frame(8'h00, 1'b1, s2);
        model_frame(s2, 8'h00, 1'b1);
        repeat (5) @(negedge clk);
        n_checks++; if (obs_done_cyc_q.size() != 1) begin n_fail++; $display("FAIL ferr_recover_count got=%0d exp=1", obs_done_cyc_q.size()); end
        if (obs_done_cyc_q.size() >= 1) begin
            n_checks++; if (obs_done_cyc_q[0] != exp_done_cyc_q[0]) begin n_fail++; $display("FAIL ferr_recover_cycle got=%0d exp=%0d", obs_done_cyc_q[0], exp_done_cyc_q[0]); end
        end
        n_checks++; if (rx_data !== model_rx_data) begin n_fail++; $display("FAIL ferr_recover_data got=%h exp=%h", rx_data, model_rx_data); end
    endtask

    task automatic test_back_to_back();
        int s1;
        int s2;
        clear_all();
        drive_frame(8'h01, 1'b1, s1);
        model_frame(s1, 8'h01, 1'b1);
        drive_frame(8'hFF, 1'b1, s2);
        model_frame(s2, 8'hFF, 1'b1);
        repeat (5) @(negedge clk);
        n_checks++; if (obs_done_cyc_q.size() != 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", obs_done_cyc_q.size()); end
        if (obs_done_cyc_q.size() == 2) begin
            n_checks++; if (obs_done_cyc_q[1] - obs_done_cyc_q[0] != 10 * BIT) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=%0d", obs_done_cyc_q[1] - obs_done_cyc_q[0], 10 * BIT); end
            for (int i = 0; i < 2; i++) begin
                n_checks++; if (obs_done_cyc_q[i] != exp_done_cyc_q[i]) begin n_fail++; $display("FAIL b2b_cycle%0d got=%0d exp=%0d", i, obs_done_cyc_q[i], exp_done_cyc_q[i]); end
                n_checks++; if (obs_data_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_data%0d got=%h exp=%h", i, obs_data_q[i], exp_q[i]); end
            end
        end
        n_checks++; if (rx_data !== model_rx_data) begin n_fail++; $display("FAIL b2b_rx_data got=%h exp=%h", rx_data, model_rx_data); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] bits;
        int s;
        clear_all();
        bits = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 4; i++) begin
            rx = bits[i];
            repeat (BIT) @(negedge clk);
        end
        rx = bits[4];
        repeat (HALF) @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        reset = 1'b0;
        model_rx_data = 8'h00;
        repeat (120) @(negedge clk);
        n_checks++; if (obs_done_cyc_q.size() + obs_err_cyc_q.size() != 0) begin n_fail++; $display("FAIL rstmid_pulses got=%0d exp=0", obs_done_cyc_q.size() + obs_err_cyc_q.size()); end
        n_checks++; if (rx_data !== model_rx_data) begin n_fail++; $display("FAIL rstmid_rx_data got=%h exp=%h", rx_data, model_rx_data); end
        drive_frame(8'h5A, 1'b1, s);
        model_frame(s, 8'h5A, 1'b1);
        repeat (5) @(negedge clk);
        n_checks++; if (obs_done_cyc_q.size() != 1) begin n_fail++; $display("FAIL rstmid_full_count got=%0d exp=1", obs_done_cyc_q.size()); end
        if (obs_done_cyc_q.size() >= 1) begin
            n_checks++; if (obs_done_cyc_q[0] != exp_done_cyc_q[0]) begin n_fail++; $display("FAIL rstmid_full_cycle got=%0d exp=%0d", obs_done_cyc_q[0], exp_done_cyc_q[0]); end
        end
        n_checks++; if (rx_data !== model_rx_data) begin n_fail++; $display("FAIL rstmid_full_data got=%h exp=%h", rx_data, model_rx_data); end
    endtask

    task automatic test_random();
        int s;
        int gap;
        logic [7:0] b;
        logic ok;
        logic prev_bad;
        int n;
        clear_all();
        prev_bad = 1'b0;
        for (int f = 0; f < 24; f++) begin
            gap = prev_bad ? int'($urandom_range(2, 6)) : int'($urandom_range(0, 4));
            rx = 1'b1;
            repeat (gap) @(negedge clk);
            b  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            drive_frame(b, ok, s);
            model_frame(s, b, ok);
            prev_bad = !ok;
        end
        rx = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (obs_done_cyc_q.size() != exp_done_cyc_q.size()) begin n_fail++; $display("FAIL rand_done_count got=%0d exp=%0d", obs_done_cyc_q.size(), exp_done_cyc_q.size()); end
        n = (obs_done_cyc_q.size() < exp_done_cyc_q.size()) ? obs_done_cyc_q.size() : exp_done_cyc_q.size();
        for (int i = 0; i < n; i++) begin
            n_checks++; if (obs_done_cyc_q[i] != exp_done_cyc_q[i]) begin n_fail++; $display("FAIL rand_done_cycle%0d got=%0d exp=%0d", i, obs_done_cyc_q[i], exp_done_cyc_q[i]); end
            n_checks++; if (obs_data_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_data%0d got=%h exp=%h", i, obs_data_q[i], exp_q[i]); end
            n_checks++; if (obs_busy_q[i] !== 1'b0) begin n_fail++; $display("FAIL rand_busy_at_done%0d got=%b exp=0", i, obs_busy_q[i]); end
        end
        n_checks++; if (obs_err_cyc_q.size() != exp_err_cyc_q.size()) begin n_fail++; $display("FAIL rand_err_count got=%0d exp=%0d", obs_err_cyc_q.size(), exp_err_cyc_q.size()); end
        n = (obs_err_cyc_q.size() < exp_err_cyc_q.size()) ? obs_err_cyc_q.size() : exp_err_cyc_q.size();
        for (int i = 0; i < n; i++) begin
            n_checks++; if (obs_err_cyc_q[i] != exp_err_cyc_q[i]) begin n_fail++; $display("FAIL rand_err_cycle%0d got=%0d exp=%0d", i, obs_err_cyc_q[i], exp_err_cyc_q[i]); end
        end
        n_checks++; if (rx_data !== model_rx_data) begin n_fail++; $display("FAIL rand_rx_data got=%h exp=%h", rx_data, model_rx_data); end
        n_checks++; if (both_cnt != 0) begin n_fail++; $display("FAIL done_and_err_together got=%0d exp=0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_a5();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
